// File: rtl/ysyx_040066_scoreboard_if.sv
// ID/WB-to-scoreboard bundle: decoded-instruction operands, issue/retire/flush events,
// and the hazard verdicts returned to the ID stage.
interface ysyx_040066_scoreboard_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_regwr;
  logic       issue;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       flush;
  logic       rs1_valid;
  logic       rs2_valid;
  logic       rd_full;
  logic       issue_ok;
  logic       busy;
  logic       err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwr,
           issue, wb_valid, wb_rd, flush,
    input  rs1_valid, rs2_valid, rd_full, issue_ok, busy, err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwr,
           issue, wb_valid, wb_rd, flush,
    output rs1_valid, rs2_valid, rd_full, issue_ok, busy, err
  );
endinterface

// File: rtl/ysyx_040066_scoreboard.sv
// Per-register pending-write scoreboard. Define YSYX_040066_SB_WB_BYPASS_EN to treat a
// source whose only pending write retires this cycle as ready (writeback forwarding).
module ysyx_040066_sb_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt
);
  // Saturation and underflow guards are applied by the caller on inc/dec.
  always_ff @(posedge clk) begin
    if (!rst)               cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (inc && !dec)   cnt <= cnt + 1'b1;
    else if (dec && !inc)   cnt <= cnt - 1'b1;
  end
endmodule

module ysyx_040066_scoreboard #(
  parameter int NREG = 32,
  parameter int CW   = 2
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_040066_scoreboard_if.slave  sb
);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam logic [CW-1:0] CONE = {{(CW-1){1'b0}}, 1'b1};

  logic [NREG-1:0][CW-1:0] cnt;
  logic [NREG-1:0]         inc;
  logic [NREG-1:0]         dec;
  logic [CW-1:0]           c_rs1, c_rs2, c_rd, c_wb;
  logic                    inc_en, dec_en, rs1_ok, rs2_ok, full;

  always_comb begin
    c_rs1 = '0;
    c_rs2 = '0;
    c_rd  = '0;
    c_wb  = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sb.id_rs1 == 5'(i)) c_rs1 = cnt[i];
      if (sb.id_rs2 == 5'(i)) c_rs2 = cnt[i];
      if (sb.id_rd  == 5'(i)) c_rd  = cnt[i];
      if (sb.wb_rd  == 5'(i)) c_wb  = cnt[i];
    end
  end

`ifdef YSYX_040066_SB_WB_BYPASS_EN
  assign rs1_ok = (c_rs1 == '0) || (c_rs1 == CONE && sb.wb_valid && sb.wb_rd == sb.id_rs1);
  assign rs2_ok = (c_rs2 == '0) || (c_rs2 == CONE && sb.wb_valid && sb.wb_rd == sb.id_rs2);
`else
  assign rs1_ok = (c_rs1 == '0);
  assign rs2_ok = (c_rs2 == '0);
`endif

  assign sb.rs1_valid = rs1_ok || !sb.id_use_rs1 || (sb.id_rs1 == 5'd0);
  assign sb.rs2_valid = rs2_ok || !sb.id_use_rs2 || (sb.id_rs2 == 5'd0);
  assign full         = sb.id_regwr && (sb.id_rd != 5'd0) && (c_rd == CMAX);
  assign sb.rd_full   = full;
  assign sb.issue_ok  = sb.id_valid && sb.rs1_valid && sb.rs2_valid && !full && !sb.flush;
  assign sb.busy      = |cnt;

  // issue is taken as-is from EX; an issue onto a full counter is dropped and flagged.
  assign inc_en = sb.issue && sb.id_regwr && (sb.id_rd != 5'd0) && !full;
  assign dec_en = sb.wb_valid && (sb.wb_rd != 5'd0) && (c_wb != '0);

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_reg
      assign inc[g] = inc_en && (sb.id_rd == 5'(g));
      assign dec[g] = dec_en && (sb.wb_rd == 5'(g));
      if (g == 0) begin : g_zero
        assign cnt[g] = '0;
      end else begin : g_cnt
        ysyx_040066_sb_cnt #(.CW(CW)) u_cnt (
          .clk (clk),
          .rst (rst),
          .clr (sb.flush),
          .inc (inc[g]),
          .dec (dec[g]),
          .cnt (cnt[g])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) sb.err <= 1'b0;
    else if ((sb.issue && full) || (sb.wb_valid && sb.wb_rd != 5'd0 && c_wb == '0))
      sb.err <= 1'b1;
  end
endmodule

// File: tb/tb_ysyx_040066_scoreboard.sv
// Directed bench for the scoreboard: hazard detection, saturation, flush, reset and err.
module tb_ysyx_040066_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ysyx_040066_scoreboard_if sb();

  ysyx_040066_scoreboard #(.NREG(32), .CW(2)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

`ifdef YSYX_040066_SB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sb.id_valid = 1'b0; sb.id_rs1 = 5'd0; sb.id_rs2 = 5'd0;
    sb.id_use_rs1 = 1'b0; sb.id_use_rs2 = 1'b0; sb.id_rd = 5'd0;
    sb.id_regwr = 1'b0; sb.issue = 1'b0; sb.wb_valid = 1'b0;
    sb.wb_rd = 5'd0; sb.flush = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] rd);
    sb.id_rd = rd; sb.id_regwr = 1'b1; sb.issue = 1'b1;
    tick();
    sb.id_regwr = 1'b0; sb.issue = 1'b0;
  endtask

  task automatic do_wb(input logic [4:0] rd);
    sb.wb_valid = 1'b1; sb.wb_rd = rd;
    tick();
    sb.wb_valid = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_rs1_valid", sb.rs1_valid, 1'b1);
    chk("rst_rs2_valid", sb.rs2_valid, 1'b1);
    chk("rst_rd_full",   sb.rd_full,   1'b0);
    chk("rst_busy",      sb.busy,      1'b0);
    chk("rst_err",       sb.err,       1'b0);
    chk("rst_issue_ok",  sb.issue_ok,  1'b0);

    // Clean source, nothing in flight
    sb.id_valid = 1'b1; sb.id_rs1 = 5'd5; sb.id_use_rs1 = 1'b1;
    #1;
    chk("clean_rs1_valid", sb.rs1_valid, 1'b1);
    chk("clean_issue_ok",  sb.issue_ok,  1'b1);
    chk("clean_busy",      sb.busy,      1'b0);

    // RAW on x7, released by writeback
    do_issue(5'd7);
    sb.id_rs2 = 5'd7; sb.id_use_rs2 = 1'b1;
    #1;
    chk("raw_rs2_valid", sb.rs2_valid, 1'b0);
    chk("raw_issue_ok",  sb.issue_ok,  1'b0);
    chk("raw_busy",      sb.busy,      1'b1);
    sb.id_use_rs2 = 1'b0;
    #1;
    chk("raw_unused_rs2", sb.rs2_valid, 1'b1);
    sb.id_use_rs2 = 1'b1;
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd7;
    #1;
    chk("raw_wb_same_cycle", sb.issue_ok, BYP);
    tick();
    sb.wb_valid = 1'b0;
    #1;
    chk("raw_wb_next_cycle", sb.issue_ok, 1'b1);
    chk("raw_drained_busy",  sb.busy,     1'b0);
    idle();
    sb.id_valid = 1'b1;

    // Saturate x3, then force an issue onto the full counter
    do_issue(5'd3); do_issue(5'd3);
    sb.id_rd = 5'd3; sb.id_regwr = 1'b1;
    #1;
    chk("sat_not_full_at_2", sb.rd_full, 1'b0);
    do_issue(5'd3);
    sb.id_regwr = 1'b1;
    #1;
    chk("sat_rd_full",  sb.rd_full,  1'b1);
    chk("sat_issue_ok", sb.issue_ok, 1'b0);
    chk("sat_err_pre",  sb.err,      1'b0);
    do_issue(5'd3);
    sb.id_regwr = 1'b1;
    #1;
    chk("sat_err_set",     sb.err,     1'b1);
    chk("sat_still_full",  sb.rd_full, 1'b1);
    sb.id_regwr = 1'b0;
    sb.id_rs1 = 5'd3; sb.id_use_rs1 = 1'b1;
    do_wb(5'd3); do_wb(5'd3);
    #1;
    chk("sat_one_left", sb.rs1_valid, 1'b0);
    do_wb(5'd3);
    #1;
    chk("sat_drained_rs1", sb.rs1_valid, 1'b1);
    chk("sat_drained_busy", sb.busy,     1'b0);
    chk("sat_err_sticky",  sb.err,      1'b1);

    // Same-register inc and dec cancel
    sb.id_rs1 = 5'd9;
    do_issue(5'd9);
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd9;
    sb.id_rd = 5'd9; sb.id_regwr = 1'b1; sb.issue = 1'b1;
    #1;
    chk("cancel_bypass_rs1", sb.rs1_valid, BYP);
    tick();
    sb.wb_valid = 1'b0; sb.issue = 1'b0; sb.id_regwr = 1'b0;
    #1;
    chk("cancel_rs1_pending", sb.rs1_valid, 1'b0);
    do_wb(5'd9);
    #1;
    chk("cancel_cnt_was_1", sb.rs1_valid, 1'b1);
    chk("cancel_busy",      sb.busy,      1'b0);

    // Inc on x10 and dec on x11 in the same cycle both apply
    do_issue(5'd11);
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd11;
    do_issue(5'd10);
    sb.wb_valid = 1'b0;
    sb.id_rs1 = 5'd10; sb.id_rs2 = 5'd11; sb.id_use_rs2 = 1'b1;
    #1;
    chk("split_rs1_x10", sb.rs1_valid, 1'b0);
    chk("split_rs2_x11", sb.rs2_valid, 1'b1);
    do_wb(5'd10);
    #1;
    chk("split_busy", sb.busy, 1'b0);

    // Flush beats a concurrent issue
    do_issue(5'd4); do_issue(5'd4); do_issue(5'd8);
    sb.id_rs1 = 5'd4; sb.id_rs2 = 5'd8;
    sb.flush = 1'b1; sb.id_rd = 5'd4; sb.id_regwr = 1'b1; sb.issue = 1'b1;
    #1;
    chk("flush_busy_pre", sb.busy,     1'b1);
    chk("flush_issue_ok", sb.issue_ok, 1'b0);
    tick();
    sb.flush = 1'b0; sb.issue = 1'b0; sb.id_regwr = 1'b0;
    #1;
    chk("flush_busy",  sb.busy,      1'b0);
    chk("flush_rs1_4", sb.rs1_valid, 1'b1);
    chk("flush_rs2_8", sb.rs2_valid, 1'b1);

    // Reset overrides an issue in the same cycle and clears err
    do_issue(5'd6);
    rst = 1'b0;
    do_issue(5'd6);
    rst = 1'b1;
    #1;
    chk("midrst_busy", sb.busy, 1'b0);
    chk("midrst_err",  sb.err,  1'b0);

    // x0 is never tracked; retire onto an idle counter is an error
    do_issue(5'd0);
    #1;
    chk("x0_busy", sb.busy, 1'b0);
    do_wb(5'd0);
    #1;
    chk("x0_wb_no_err", sb.err, 1'b0);
    do_wb(5'd12);
    #1;
    chk("wb_idle_err", sb.err, 1'b1);
    tick(); tick();
    chk("wb_idle_err_sticky", sb.err, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("err_cleared_by_rst", sb.err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_040066_scoreboard.md
YSYX_040066_SCOREBOARD -- requirements
Module: ysyx_040066_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural integer registers tracked.
REQ-002 SHALL have parameter CW, default 2, width of each per-register pending-write counter.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low: rst=0 at a rising edge resets.
REQ-005 id_valid  input  1  ID holds a decoded instruction this cycle.
REQ-006 id_rs1, id_rs2  input  5 each  source register indices.
REQ-007 id_use_rs1, id_use_rs2  input  1 each  instruction reads that source.
REQ-008 id_rd  input  5  destination index; id_regwr  input  1  instruction writes rd.
REQ-009 issue  input  1  ID instruction accepted by EX this cycle.
REQ-010 wb_valid  input  1  a register write retires this cycle; wb_rd  input  5  its index.
REQ-011 flush  input  1  all in-flight instructions squashed (trap/redirect).
REQ-012 rs1_valid, rs2_valid  output  1 each  source operand has no pending write.
REQ-013 rd_full  output  1  rd counter saturated, issue not permitted.
REQ-014 issue_ok  output  1  ID instruction may issue this cycle.
REQ-015 busy  output  1  at least one counter nonzero (drain indicator for fence.i/CSR).
REQ-016 err  output  1  sticky protocol-violation flag.

Function
REQ-017 SHALL hold one CW-bit counter per register; register 0 counter SHALL be constant 0.
REQ-018 rsN_valid = (cnt[id_rsN]==0) | ~id_use_rsN | (id_rsN==0); purely combinational, same cycle.
REQ-019 rd_full = id_regwr & (id_rd!=0) & (cnt[id_rd]==2^CW-1).
REQ-020 issue_ok = id_valid & rs1_valid & rs2_valid & ~rd_full & ~flush.
REQ-021 Counter increment on issue & id_regwr & (id_rd!=0) & ~rd_full; decrement on wb_valid & (wb_rd!=0) & cnt[wb_rd]!=0.
REQ-022 Increment and decrement of the same register in one cycle SHALL leave its counter unchanged.
REQ-023 Increment on one register and decrement on another in the same cycle SHALL both apply.
REQ-024 Counters SHALL never wrap: saturated increment suppressed, zero decrement suppressed.
REQ-025 err SHALL set on issue while rd_full, or wb_valid with wb_rd!=0 and cnt[wb_rd]==0; cleared only by reset.
REQ-026 flush=1 SHALL clear all counters next cycle, overriding any issue or wb in that cycle; err updates still evaluated.
REQ-027 busy = OR of all counters, registered-state based (reflects current counters, no lookahead).
REQ-028 issue is sampled regardless of issue_ok; block does not gate it.

Reset
REQ-029 On rst=0 at a rising edge all counters SHALL become 0 and err 0, overriding flush, issue and wb.
REQ-030 Outputs after reset: rs1_valid=1, rs2_valid=1, rd_full=0, busy=0, err=0, issue_ok=id_valid.
REQ-031 Reset mid-operation SHALL discard all pending state; no late wb SHALL set err until a new issue... unless wb targets a zero counter (REQ-025 applies unchanged).

Configuration
REQ-032 Macro YSYX_040066_SB_WB_BYPASS_EN: when defined, rsN_valid SHALL also be 1 when cnt[id_rsN]==1 & wb_valid & wb_rd==id_rsN (writeback forwarded same cycle).
REQ-033 Without YSYX_040066_SB_WB_BYPASS_EN, rsN_valid SHALL follow REQ-018 only; a dependent instruction issues one cycle after the retiring write.

Verification
REQ-034 Reset, then id_valid=1, id_rs1=5, id_use_rs1=1, no prior issue -> rs1_valid=1, issue_ok=1, busy=0.
REQ-035 Issue rd=7; next cycle id_rs2=7 used -> rs2_valid=0, issue_ok=0; wb_rd=7 -> issue_ok=1 same cycle with bypass macro, next cycle without.
REQ-036 Issue rd=3 three times, no wb -> rd_full=1 on fourth attempt; forced issue -> err=1, cnt[3] stays 3.
REQ-037 cnt[9]=1, same cycle issue rd=9 and wb_rd=9 -> cnt[9] stays 1, rs1_valid for rs1=9 stays 0.
REQ-038 cnt[4]=2, cnt[8]=1, flush=1 with simultaneous issue rd=4 -> next cycle all counters 0, busy=0.
REQ-039 Issue rd=0 with id_regwr=1 -> busy stays 0; wb_valid with wb_rd=12 while cnt[12]=0 -> err=1 until rst=0.
